// File: rtl/vga_pkg.sv
// Default VGA 640x480@60 timing constants and small helpers shared by the
// timing generator, its axis counters and its interface.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int   VGA_CLK_DIV     = 2;
    localparam int   VGA_H_VISIBLE   = 640;
    localparam int   VGA_H_FRONT     = 16;
    localparam int   VGA_H_SYNC      = 96;
    localparam int   VGA_H_BACK      = 48;
    localparam int   VGA_V_VISIBLE   = 480;
    localparam int   VGA_V_FRONT     = 10;
    localparam int   VGA_V_SYNC      = 2;
    localparam int   VGA_V_BACK      = 33;
    localparam logic VGA_SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Display-path bundle: scan coordinates and DAC outputs from the timing
// generator (master), colour returned by color_mapper (slave).
interface vga_timing_gen_if
    import vga_pkg::*;
;
    logic [7:0]       Red_in;
    logic [7:0]       Green_in;
    logic [7:0]       Blue_in;
    logic [CNT_W-1:0] DrawX;
    logic [CNT_W-1:0] DrawY;
    logic             pixel_ce;
    logic             hs;
    logic             vs;
    logic             blank_n;
    logic [7:0]       Red;
    logic [7:0]       Green;
    logic [7:0]       Blue;
    logic             frame_start;
    logic [15:0]      frame_count;

    modport master (
        input  Red_in, Green_in, Blue_in,
        output DrawX, DrawY, pixel_ce, hs, vs, blank_n,
        output Red, Green, Blue, frame_start, frame_count
    );

    modport slave (
        output Red_in, Green_in, Blue_in,
        input  DrawX, DrawY, pixel_ce, hs, vs, blank_n,
        input  Red, Green, Blue, frame_start, frame_count
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping position counter plus its raw sync and
// visible-region decodes.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 751,
    parameter int VISIBLE    = 640
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_raw,
    output logic             active_raw
);

    logic [CNT_W-1:0] r_count;

    // NOTE: registers take <= so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= wrap ? '0 : r_count + CNT_W'(1);
        end
    end

    assign count      = r_count;
    assign wrap       = (r_count == CNT_W'(TOTAL - 1));
    assign sync_raw   = in_window(r_count, CNT_W'(SYNC_START), CNT_W'(SYNC_END));
    assign active_raw = (r_count < CNT_W'(VISIBLE));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing source: scan coordinates out, colour back in, one-pixel
// registered output stage aligning RGB with hs/vs/blank_n, per-frame pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV     = VGA_CLK_DIV,
    parameter int   H_VISIBLE   = VGA_H_VISIBLE,
    parameter int   H_FRONT     = VGA_H_FRONT,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BACK      = VGA_H_BACK,
    parameter int   V_VISIBLE   = VGA_V_VISIBLE,
    parameter int   V_FRONT     = VGA_V_FRONT,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BACK      = VGA_V_BACK,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic           Clk,
    input  logic           Reset,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL      = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL      = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             w_pixel_ce;
    logic [CNT_W-1:0] w_h_count, w_v_count;
    logic             w_h_wrap, w_v_wrap;
    logic             w_h_sync, w_v_sync;
    logic             w_h_active, w_v_active;
    logic             w_active;
    logic             w_frame_start;
    logic             w_unused_v_wrap;

    logic             r_hs, r_vs, r_blank_n;
    rgb_t             r_rgb;
    logic [15:0]      r_frame_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div <= '0;
        end else begin
            r_div <= w_pixel_ce ? '0 : r_div + DIV_W'(1);
        end
    end

    assign w_pixel_ce = (r_div == DIV_W'(CLK_DIV - 1));

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_START + H_SYNC - 1),
        .VISIBLE    (H_VISIBLE)
    ) u_h_axis (
        .Clk        (Clk),
        .Reset      (Reset),
        .inc        (w_pixel_ce),
        .count      (w_h_count),
        .wrap       (w_h_wrap),
        .sync_raw   (w_h_sync),
        .active_raw (w_h_active)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_START + V_SYNC - 1),
        .VISIBLE    (V_VISIBLE)
    ) u_v_axis (
        .Clk        (Clk),
        .Reset      (Reset),
        .inc        (w_pixel_ce & w_h_wrap),
        .count      (w_v_count),
        .wrap       (w_v_wrap),
        .sync_raw   (w_v_sync),
        .active_raw (w_v_active)
    );

    // The frame wraps together with the line, so the vertical terminal count has no consumer.
    assign w_unused_v_wrap = w_v_wrap;

    assign w_active      = w_h_active & w_v_active;
    assign w_frame_start = w_pixel_ce & w_h_wrap & (w_v_count == CNT_W'(V_VISIBLE - 1));

    // Output stage holds the decode of the coordinate just left, so colour and syncs stay paired.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hs          <= ~SYNC_ACTIVE;
            r_vs          <= ~SYNC_ACTIVE;
            r_blank_n     <= 1'b0;
            r_rgb         <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_pixel_ce) begin
                r_hs      <= w_h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vs      <= w_v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_blank_n <= w_active;
                r_rgb     <= w_active ? rgb_t'{r: vif.Red_in, g: vif.Green_in, b: vif.Blue_in}
                                      : rgb_t'('0);
            end
            if (w_frame_start) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign vif.DrawX       = w_h_count;
    assign vif.DrawY       = w_v_count;
    assign vif.pixel_ce    = w_pixel_ce;
    assign vif.hs          = r_hs;
    assign vif.vs          = r_vs;
    assign vif.blank_n     = r_blank_n;
    assign vif.Red         = r_rgb.r;
    assign vif.Green       = r_rgb.g;
    assign vif.Blue        = r_rgb.b;
    assign vif.frame_start = w_frame_start;
    assign vif.frame_count = r_frame_count;

endmodule
